// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: address/instruction widths, reset PC,
// HLT opcode and the fetch FSM state type.
package wisc_pkg;

    localparam int unsigned        ADDR_W   = 16;
    localparam int unsigned        INSTR_W  = 16;
    localparam logic [ADDR_W-1:0]  RESET_PC = 16'h0000;
    localparam logic [3:0]         OPC_HLT  = 4'hF;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Loadable PC register: async reset to RESET_PC, load has priority over
// the sequential increment.
module pc_reg #(
    parameter int unsigned       ADDR_W   = wisc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = wisc_pkg::RESET_PC,
    parameter int unsigned       PC_INC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= q + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// WISC fetch unit: owns the PC, runs the imem req/ready handshake and feeds decode.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = wisc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = wisc_pkg::RESET_PC,
    parameter int unsigned       PC_INC   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    input  logic                         halt_i,
    output logic                         imem_req_o,
    output logic [ADDR_W-1:0]            imem_addr_o,
    input  logic                         imem_ready_i,
    input  logic [wisc_pkg::INSTR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0]            pc_o,
    output logic [ADDR_W-1:0]            pc_next_o,
    output logic [wisc_pkg::INSTR_W-1:0] instr_o,
    output logic                         instr_valid_o,
    output logic                         halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                  fetch_cnt_o,
    output logic [15:0]                  stall_cnt_o
`endif
);

    import wisc_pkg::*;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] addr_q;
    logic              squash, squash_nxt;
    logic              hold;
    logic              issue;
    logic              capture;
    logic              go_halt;
    logic              redirect_ok;

    assign hold        = instr_valid_o && stall_i;
    assign redirect_ok = redirect_i && (state != HALT);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_fetch_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (redirect_ok),
        .inc      (capture),
        .load_val (redirect_pc_i),
        .q        (fetch_pc)
    );

    always_comb begin
        state_nxt  = state;
        squash_nxt = squash;
        issue      = 1'b0;
        capture    = 1'b0;
        go_halt    = 1'b0;
        case (state)
            FETCH: begin
                if (halt_i && instr_valid_o && !redirect_i) begin
                    go_halt   = 1'b1;
                    state_nxt = HALT;
                end else if ((!instr_valid_o || !stall_i) && !halt_i && !redirect_i) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A ready coinciding with redirect retires the old request, so no squash is owed.
                if (redirect_i) begin
                    if (imem_ready_i) begin
                        squash_nxt = 1'b0;
                        state_nxt  = FETCH;
                    end else begin
                        squash_nxt = 1'b1;
                    end
                end else if (halt_i && instr_valid_o) begin
                    go_halt   = 1'b1;
                    state_nxt = HALT;
                end else if (imem_ready_i && !hold) begin
                    capture    = !squash;
                    squash_nxt = 1'b0;
                    state_nxt  = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            squash        <= 1'b0;
            addr_q        <= RESET_PC;
            pc_o          <= RESET_PC;
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            squash <= squash_nxt;
            if (issue) begin
                addr_q <= fetch_pc;
            end
            if (capture) begin
                instr_o       <= imem_data_i;
                pc_o          <= addr_q;
                instr_valid_o <= 1'b1;
            end else if (redirect_ok || go_halt || !stall_i) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

    assign imem_req_o  = (state == WAIT);
    assign imem_addr_o = addr_q;
    assign halted_o    = (state == HALT);
    assign pc_next_o   = pc_o + ADDR_W'(PC_INC);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (state != HALT) begin
            if (capture && (fetch_cnt_o != '1)) begin
                fetch_cnt_o <= fetch_cnt_o + 16'd1;
            end
            if (hold && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and drives instruction fetch for the WISC core.
- Supplies the current PC to the branch/PC-control logic and accepts its resolved branch target back as a redirect.
- Sits between the instruction memory or I-cache (req/ready handshake, variable latency) and the decode stage.
- Handles stall, branch redirect, squash of in-flight fetches and HLT.

Parameters:
ADDR_W, 16, PC/address width
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per sequential instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  decode cannot accept; hold instr_o/pc_o
redirect_i  in  1  taken branch resolved by PC control
redirect_pc_i  in  ADDR_W  branch target (PC control output)
halt_i  in  1  decode identified HLT in instr_o
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address, stable while req high
imem_ready_i  in  1  memory returns data this cycle
imem_data_i  in  16  fetched instruction word
pc_o  out  ADDR_W  PC of instr_o (feeds PC control PC_in)
pc_next_o  out  ADDR_W  pc_o + PC_INC
instr_o  out  16  instruction to decode
instr_valid_o  out  1  instr_o valid
halted_o  out  1  core halted

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - pc_o = RESET_PC; fetch_pc = RESET_PC
  - instr_o = 16'h0; instr_valid_o = 0
  - imem_req_o = 0; halted_o = 0
  - squash = 0; state = FETCH
- Reset asserted mid-request abandons the request; any later ready is ignored until req is reissued.
- FSM states: FETCH, WAIT, HALT.
- FETCH:
  - Issue condition: (!instr_valid_o || !stall_i) && !halt_i && !redirect_i.
  - On issue: imem_req_o = 1, imem_addr_o = fetch_pc, go to WAIT.
- WAIT:
  - req and addr are held unchanged until imem_ready_i is sampled high.
  - On ready with squash = 0: instr_o <= imem_data_i, pc_o <= fetch_pc, instr_valid_o <= 1, fetch_pc <= fetch_pc + PC_INC (mod 2^ADDR_W, FFFE wraps to 0000).
  - Next state is FETCH. A new request may issue the following cycle.
  - Throughput is 1 instruction per 2 cycles with zero-wait memory.
- Consumption: instr_valid_o clears when stall_i = 0 and no new data arrives in that edge.
- Redirect (highest priority after reset), in any state except HALT:
  - fetch_pc <= redirect_pc_i; instr_valid_o <= 0.
  - In WAIT without ready: squash <= 1. The next ready is dropped and squash clears; the FSM returns to FETCH.
  - In WAIT with ready in the same cycle: data is dropped.
- Redirect beats halt_i in the same cycle, because the branch is older.
- Stall with instr_valid_o = 1: no new request is issued; instr_o and pc_o hold. An outstanding WAIT still completes only after stall drops. Ready is not accepted while (instr_valid_o && stall_i); req is held.
- halt_i while instr_valid_o && !redirect_i:
  - Go to HALT: halted_o = 1, imem_req_o = 0, instr_valid_o = 0.
  - pc_o keeps the HLT address.
  - HALT is left only by reset. An outstanding fetch at halt is abandoned.
- pc_next_o is combinational: pc_o + PC_INC.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt_o[15:0] (accepted, non-squashed instructions) and stall_cnt_o[15:0] (cycles with instr_valid_o && stall_i).
  - Both are saturating at FFFF, reset to 0, and frozen in HALT.
- Undefined: no counters and no such ports; behaviour is otherwise identical.

Decomposition:
- Shared package wisc_pkg:
  - typedef fetch_state_t {FETCH, WAIT, HALT}
  - ADDR_W and RESET_PC constants
  - INSTR_W = 16
  - OPC_HLT = 4'hF
- One natural sub-module: pc_reg, a loadable ADDR_W register with async reset to RESET_PC and increment/load select.
- FSM and handshake stay in the top module.

Test Plan:
- Sequential fetch, zero-wait memory: reset, then words at 0000/0002/0004 → instr_valid pulses with pc_o = 0000, 0002, 0004 in order; imem_addr_o never changes while req high.
- Variable latency: ready delayed 3 cycles → imem_addr_o = 0002 held for all 4 req cycles; instr_o captured only on the ready edge.
- Redirect during WAIT: fetch at 0004 outstanding, redirect_pc_i = 0040 → the ready for 0004 is dropped (no valid); next req address = 0040; pc_o = 0040 on capture.
- Simultaneous redirect + halt_i: redirect to 0010 wins → halted_o stays 0; fetch resumes at 0010. A later halt_i alone → halted_o = 1, req stays 0 for 20 cycles, pc_o holds the HLT address.
- Stall hold: instr at 0006 valid with stall_i high for 5 cycles → instr_o/pc_o constant, no new req; stall low → next req at 0008. With FETCH_PERF_CNT_EN, stall_cnt_o = 5.
- Wrap and reset: fetch_pc = FFFE captured → next req address = 0000. Assert rst mid-WAIT → all outputs return to reset values asynchronously; the first request after release is at RESET_PC.
